// File: rtl/dds_pkg.sv
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared definitions for the DDS generator / frequency meter
//                pair: phase accumulator width and the meter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dds_pkg;

    // Width of the DDS phase accumulator (and of the tuning word)
    localparam int ACC_W = 32;

    // Frequency meter state encoding (explicit 2-bit width)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } meter_state_t;

endpackage : dds_pkg

`default_nettype wire

// File: rtl/dds_freq_meter_if.sv
// ============================================================================
//  Module      : dds_freq_meter_if
//  Description : Control / result bundle of the frequency meter. The master
//                side requests measurements, the slave side (the meter)
//                returns the measured tuning word and status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dds_freq_meter_if;
    import dds_pkg::*;

    logic             start;
    logic             continuous;
    logic             busy;
    logic [ACC_W-1:0] K_meas;
    logic             K_valid;
    logic             no_signal;

    modport master (
        output start,
        output continuous,
        input  busy,
        input  K_meas,
        input  K_valid,
        input  no_signal
    );

    modport slave (
        input  start,
        input  continuous,
        output busy,
        output K_meas,
        output K_valid,
        output no_signal
    );

endinterface : dds_freq_meter_if

`default_nettype wire

// File: rtl/dds_edge_sync.sv
// ============================================================================
//  Module      : dds_edge_sync
//  Description : Multi-flop synchronizer for an asynchronous square wave,
//                followed by a delay flop and a rising-edge detector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_in,
    output logic      rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;

    // Synchronizer chain plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], d_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    // One-cycle pulse on each synchronized low-to-high transition
    assign rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule : dds_edge_sync

`default_nettype wire

// File: rtl/dds_freq_meter.sv
// ============================================================================
//  Module      : dds_freq_meter
//  Description : Measures the frequency of an asynchronous square wave over a
//                2^GATE_LOG2-cycle gate window and reports it as the DDS
//                tuning word K = f_in * 2^32 / f_clk. The window length is a
//                power of two, so the result is a plain shift of the edge
//                count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int GATE_LOG2   = 20,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          F_in,
    dds_freq_meter_if.slave    bus
);

    localparam logic [GATE_LOG2-1:0] c_cnt_max = '1;
    localparam logic [GATE_LOG2-1:0] c_cnt_one = GATE_LOG2'(1);

    meter_state_t           r_state;
    meter_state_t           w_state_next;
    logic [GATE_LOG2-1:0]   r_timer;
    logic [GATE_LOG2-1:0]   r_edges;
    logic [GATE_LOG2-1:0]   w_edges_next;
    logic [ACC_W-1:0]       r_k_meas;
    logic                   r_k_valid;
    logic                   r_no_signal;
    logic                   w_rise;
    logic                   w_clr_timer;
    logic                   w_clr_edges;
    logic                   w_count_edge;
    logic                   w_to_done;
    logic                   w_timeout;
    logic [ACC_W-1:0]       w_k_calc;

    dds_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d_in (F_in),
        .rise (w_rise)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_clr_timer  = 1'b0;
        w_clr_edges  = 1'b0;
        w_count_edge = 1'b0;
        w_to_done    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_ARM;
                    w_clr_timer  = 1'b1;
                end
            end
            S_ARM: begin
                // The aligning edge opens the window but is not counted
                if (w_rise) begin
                    w_state_next = S_GATE;
                    w_clr_timer  = 1'b1;
                    w_clr_edges  = 1'b1;
                end else if (r_timer == c_cnt_max) begin
                    w_state_next = S_DONE;
                    w_to_done    = 1'b1;
                    w_timeout    = 1'b1;
                end
            end
            S_GATE: begin
                // Edges on every window cycle count, the last one included
                w_count_edge = w_rise;
                if (r_timer == c_cnt_max) begin
                    w_state_next = S_DONE;
                    w_to_done    = 1'b1;
                end
            end
            S_DONE: begin
                w_clr_timer  = 1'b1;
                w_state_next = bus.continuous ? S_ARM : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Cycle timer: runs in ARM (timeout) and GATE (window), wraps at 2^GATE_LOG2
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_clr_timer) begin
            r_timer <= '0;
        end else if (r_state == S_ARM || r_state == S_GATE) begin
            r_timer <= r_timer + c_cnt_one;
        end
    end

    // Edge count including this cycle's edge; saturates defensively
    assign w_edges_next = (w_count_edge && (r_edges != c_cnt_max))
                          ? (r_edges + c_cnt_one) : r_edges;

    // Edge counter inside the gate window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edges <= '0;
        end else if (w_clr_edges) begin
            r_edges <= '0;
        end else begin
            r_edges <= w_edges_next;
        end
    end

    // Window is 2^GATE_LOG2 cycles, so K = E << (32 - GATE_LOG2)
    assign w_k_calc = {w_edges_next, {(ACC_W-GATE_LOG2){1'b0}}};

    // Result registers, loaded on the transition into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_meas    <= '0;
            r_no_signal <= 1'b0;
            r_k_valid   <= 1'b0;
        end else begin
            r_k_valid <= w_to_done;
            if (w_to_done) begin
                r_k_meas    <= w_timeout ? '0 : w_k_calc;
                r_no_signal <= w_timeout;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.K_meas    = r_k_meas;
    assign bus.K_valid   = r_k_valid;
    assign bus.no_signal = r_no_signal;

endmodule : dds_freq_meter

`default_nettype wire

// File: tb/tb_dds_freq_meter.sv
// ============================================================================
//  Module      : tb_dds_freq_meter
//  Description : Directed self-checking bench for dds_freq_meter with a
//                behavioural DDS source (phase accumulator MSB) on F_in.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_freq_meter;

    localparam int GATE_LOG2 = 12;
    localparam int WIN       = 1 << GATE_LOG2;

    logic        clk;
    logic        rst;
    logic        F_in;
    logic        dds_en;
    logic [31:0] dds_k;
    logic [31:0] dds_acc;

    int n_checks;
    int n_errors;
    int busy_low_cnt;
    logic mon_on;

    dds_freq_meter_if bus ();

    dds_freq_meter #(
        .GATE_LOG2   (GATE_LOG2),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .F_in (F_in),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DDS source: F_in is the accumulator MSB
    always @(negedge clk) begin
        if (!dds_en) begin
            dds_acc = 32'd0;
        end else begin
            dds_acc = dds_acc + dds_k;
        end
        F_in = dds_acc[31];
    end

    // busy watchdog for the continuous-mode scenario
    always @(negedge clk) begin
        if (mon_on && !bus.busy) busy_low_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for the next K_valid pulse; cnt = negedges waited
    task automatic wait_valid(input int budget, output int cnt, output logic ok);
        cnt = 0;
        ok  = 1'b0;
        while (cnt < budget && !ok) begin
            @(negedge clk);
            cnt++;
            if (bus.K_valid) ok = 1'b1;
        end
    endtask

    int   cnt;
    logic ok;
    int   nvalid;
    logic [31:0] last_k;

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        busy_low_cnt = 0;
        mon_on       = 1'b0;
        dds_en       = 1'b0;
        dds_k        = 32'd0;
        dds_acc      = 32'd0;
        F_in         = 1'b0;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_value("rst_busy",      32'(bus.busy),      32'd0);
        check_value("rst_k_valid",   32'(bus.K_valid),   32'd0);
        check_value("rst_k_meas",    bus.K_meas,         32'd0);
        check_value("rst_no_signal", 32'(bus.no_signal), 32'd0);

        // 1: clk/256
        dds_k  = 32'h0100_0000;
        dds_en = 1'b1;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(2 * WIN, cnt, ok);
        check_value("t1_valid",     32'(ok),            32'd1);
        check_value("t1_k_meas",    bus.K_meas,         32'h0100_0000);
        check_value("t1_no_signal", 32'(bus.no_signal), 32'd0);
        repeat (5) @(negedge clk);

        // 2: clk/4
        dds_k = 32'h4000_0000;
        repeat (20) @(negedge clk);
        pulse_start();
        wait_valid(2 * WIN, cnt, ok);
        check_value("t2_valid",     32'(ok),            32'd1);
        check_value("t2_k_meas",    bus.K_meas,         32'h4000_0000);
        check_value("t2_no_signal", 32'(bus.no_signal), 32'd0);
        repeat (5) @(negedge clk);

        // 3: no signal -> timeout WIN cycles after entering ARM
        dds_en = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start();
        check_value("t3_busy_arm", 32'(bus.busy), 32'd1);
        wait_valid(2 * WIN, cnt, ok);
        check_value("t3_latency",   32'(cnt),           32'(WIN));
        check_value("t3_k_meas",    bus.K_meas,         32'd0);
        check_value("t3_no_signal", 32'(bus.no_signal), 32'd1);
        @(negedge clk);
        check_value("t3_idle_busy", 32'(bus.busy), 32'd0);

        // 4: continuous mode with a mid-run frequency change
        dds_k  = 32'h0100_0000;
        dds_en = 1'b1;
        repeat (20) @(negedge clk);
        bus.continuous = 1'b1;
        pulse_start();
        mon_on = 1'b1;
        wait_valid(2 * WIN, cnt, ok);
        check_value("t4_valid1",  32'(ok),    32'd1);
        check_value("t4_k_meas1", bus.K_meas, 32'h0100_0000);
        dds_k = 32'h0200_0000;
        wait_valid(2 * WIN, cnt, ok);
        check_value("t4_valid2",  32'(ok),    32'd1);
        check_value("t4_k_meas2", bus.K_meas, 32'h0200_0000);
        bus.continuous = 1'b0;
        mon_on = 1'b0;
        check_value("t4_busy_low_cycles", 32'(busy_low_cnt), 32'd0);
        @(negedge clk);
        check_value("t4_idle_busy", 32'(bus.busy), 32'd0);

        // 5: reset in the middle of GATE
        dds_k = 32'h0100_0000;
        repeat (10) @(negedge clk);
        pulse_start();
        repeat (1500) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value("t5_busy",    32'(bus.busy),    32'd0);
        check_value("t5_k_meas",  bus.K_meas,       32'd0);
        check_value("t5_k_valid", 32'(bus.K_valid), 32'd0);
        repeat (10) @(negedge clk);
        pulse_start();
        wait_valid(2 * WIN, cnt, ok);
        check_value("t5_valid",     32'(ok),            32'd1);
        check_value("t5_k_meas2",   bus.K_meas,         32'h0100_0000);
        check_value("t5_no_signal", 32'(bus.no_signal), 32'd0);
        repeat (5) @(negedge clk);

        // 6: start pulses while busy are ignored
        pulse_start();
        nvalid = 0;
        last_k = 32'd0;
        for (int i = 0; i < 2 * WIN; i++) begin
            @(negedge clk);
            bus.start = ((i % 300) == 299) && (i < 3000);
            if (bus.K_valid) begin
                nvalid++;
                last_k = bus.K_meas;
            end
        end
        bus.start = 1'b0;
        check_value("t6_valid_count", 32'(nvalid), 32'd1);
        check_value("t6_k_meas",      last_k,      32'h0100_0000);
        check_value("t6_idle_busy",   32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dds_freq_meter

`default_nettype wire
